// File: rtl/alarm_pkg.sv
// Shared definitions for the security-system alarm controller: state codes and
// the width rule for the delay counter.
package alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4
    } state_t;

    // Counter must hold the longest delay plus one spare bit.
    function automatic int count_width(input int exit_ticks, input int entry_ticks,
                                       input int alarm_ticks);
        int longest;
        longest = exit_ticks;
        if (entry_ticks > longest) longest = entry_ticks;
        if (alarm_ticks > longest) longest = alarm_ticks;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Keypad/sensor inputs and siren/LED/status outputs of the alarm controller.
interface alarm_controller_if
    import alarm_pkg::*;
#(
    parameter int NUM_ZONES = 4,
    parameter int CW        = count_width(10, 8, 60)
);
    logic                 tick;
    logic                 arm;
    logic                 code_ok;
    logic [NUM_ZONES-1:0] sensor;
    logic                 siren;
    logic                 armed_led;
    logic                 arm_fault;
    logic [STATE_W-1:0]   state;
    logic [NUM_ZONES-1:0] zone_latched;
    logic [CW-1:0]        count;

    modport master (
        output tick, arm, code_ok, sensor,
        input  siren, armed_led, arm_fault, state, zone_latched, count
    );

    modport slave (
        input  tick, arm, code_ok, sensor,
        output siren, armed_led, arm_fault, state, zone_latched, count
    );
endinterface

// File: rtl/alarm_controller_tick_timer.sv
// Loadable tick-driven down-counter; done flags the tick that consumes the
// last remaining count.
module tick_timer
    import alarm_pkg::*;
#(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          tick,
    output logic [CW-1:0] count,
    output logic          done
);
    assign done = tick && (count == CW'(1));

    // A load wins over a coincident tick, so the new delay starts in full.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/alarm_controller.sv
// Arm/disarm sequencer with exit/entry delays, siren timeout and sticky
// record of the zones that tripped while armed.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int                   NUM_ZONES   = 4,
    parameter int                   EXIT_TICKS  = 10,
    parameter int                   ENTRY_TICKS = 8,
    parameter int                   ALARM_TICKS = 60,
    parameter logic [NUM_ZONES-1:0] ENTRY_MASK  = NUM_ZONES'(1)
) (
    input  logic             clk,
    input  logic             clear,
    alarm_controller_if.slave bus
);
    localparam int CW = count_width(EXIT_TICKS, ENTRY_TICKS, ALARM_TICKS);

    state_t               state_q;
    state_t               state_d;
    logic [NUM_ZONES-1:0] latched_q;
    logic [NUM_ZONES-1:0] latched_d;
    logic                 siren_q;
    logic                 siren_d;
    logic                 led_q;
    logic                 led_d;
    logic                 fault_q;
    logic                 fault_d;
    logic                 timer_load;
    logic [CW-1:0]        timer_value;
    logic [CW-1:0]        count;
    logic                 timeout;
    logic                 trip;
    logic                 etrip;

    assign trip  = |(bus.sensor & ~ENTRY_MASK);
    assign etrip = |(bus.sensor & ENTRY_MASK);

    tick_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .clear      (clear),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (bus.tick),
        .count      (count),
        .done       (timeout)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= DISARMED;
            latched_q <= '0;
            siren_q   <= 1'b0;
            led_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            siren_q   <= siren_d;
            led_q     <= led_d;
            fault_q   <= fault_d;
        end
    end

    // code_ok is tested first in every armed state so a disarm beats any trip.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DISARMED: begin
                if (bus.arm && (bus.sensor == '0)) state_d = EXIT_DELAY;
            end
            EXIT_DELAY: begin
                if (bus.code_ok)   state_d = DISARMED;
                else if (timeout)  state_d = ARMED;
            end
            ARMED: begin
                if (bus.code_ok)   state_d = DISARMED;
                else if (trip)     state_d = ALARM;
                else if (etrip)    state_d = ENTRY_DELAY;
            end
            ENTRY_DELAY: begin
                if (bus.code_ok)           state_d = DISARMED;
                else if (trip || timeout)  state_d = ALARM;
            end
            ALARM: begin
                if (bus.code_ok)   state_d = DISARMED;
                else if (timeout)  state_d = ARMED;
            end
            default: state_d = DISARMED;
        endcase
    end

    always_comb begin
        latched_d   = latched_q;
        siren_d     = (state_d == ALARM);
        led_d       = (state_d != DISARMED);
        fault_d     = (state_q == DISARMED) && bus.arm && (bus.sensor != '0);
        timer_load  = (state_d != state_q);
        timer_value = '0;
        case (state_d)
            EXIT_DELAY:  timer_value = CW'(EXIT_TICKS);
            ENTRY_DELAY: timer_value = CW'(ENTRY_TICKS);
            ALARM:       timer_value = CW'(ALARM_TICKS);
            default:     timer_value = '0;
        endcase
        if ((state_q == DISARMED) && (state_d == EXIT_DELAY)) begin
            latched_d = '0;
        end else if (((state_q == ARMED) || (state_q == ENTRY_DELAY)) && !bus.code_ok) begin
            latched_d = latched_q | bus.sensor;
        end
    end

    assign bus.state        = state_q;
    assign bus.zone_latched = latched_q;
    assign bus.siren        = siren_q;
    assign bus.armed_led    = led_q;
    assign bus.arm_fault    = fault_q;
    assign bus.count        = count;
endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Central state machine of the residential security system.
- Sequences arm/disarm, exit and entry delays, and siren activation from zone sensor inputs.
- Latches which zone caused an alarm.
- Sits between the keypad/code-check logic, the zone sensor inputs and the siren/LED drivers.
- Advances all timing on an external 1-tick enable (nominally 1 Hz) derived from clk.

Parameters:
- NUM_ZONES, 4: number of sensor zones.
- EXIT_TICKS, 10: ticks from arm acceptance to ARMED (must be >= 1).
- ENTRY_TICKS, 8: ticks from an entry-zone trip to ALARM (must be >= 1).
- ALARM_TICKS, 60: ticks the siren sounds before auto-silencing (must be >= 1).
- ENTRY_MASK, 4'b0001: zones set here are delayed entry zones; all others are instant zones.

Ports:
- clk, input, 1: system clock.
- clear, input, 1: reset, synchronous, active-high.
- tick, input, 1: one-cycle timing enable.
- arm, input, 1: one-cycle arm request.
- code_ok, input, 1: one-cycle valid-code pulse; disarms or silences.
- sensor, input, NUM_ZONES: zone open = 1, level-sensitive.
- siren, output, 1: siren drive.
- armed_led, output, 1: high in EXIT_DELAY, ARMED, ENTRY_DELAY and ALARM.
- arm_fault, output, 1: one-cycle pulse when an arm request is rejected.
- state, output, 3: current state code.
- zone_latched, output, NUM_ZONES: zones that tripped while armed (sticky).
- count, output, CW: remaining ticks in the current timed state; CW = clog2(max of the three tick parameters) + 1.

Behaviour:
- Reset: clear is sampled on posedge clk, is synchronous and active-high, and overrides all other inputs, including mid-delay and mid-alarm. Reset values:
  - state = DISARMED
  - siren = 0, armed_led = 0, arm_fault = 0
  - zone_latched = 0, count = 0
- State codes: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. Codes 5-7 are illegal and go to DISARMED on the next clk.
- Timed-state counting: on entry to a timed state, count loads that state's parameter. Each tick decrements count. A tick with count==1 performs the timeout transition and count becomes 0. count = 0 in untimed states.
- DISARMED:
  - arm with sensor == 0 -> EXIT_DELAY.
  - arm with sensor != 0 -> stay; arm_fault = 1 for exactly one cycle.
- EXIT_DELAY: sensors are ignored.
  - code_ok -> DISARMED.
  - timeout -> ARMED.
- ARMED: let trip = sensor & ~ENTRY_MASK (instant zones) and etrip = sensor & ENTRY_MASK (entry zones).
  - code_ok -> DISARMED.
  - Any instant-zone bit set -> ALARM.
  - Otherwise, any entry-zone bit set -> ENTRY_DELAY.
  - Every open zone bit is ORed into zone_latched.
- ENTRY_DELAY:
  - code_ok -> DISARMED.
  - An instant-zone trip -> ALARM immediately.
  - timeout -> ALARM.
  - Open zones keep ORing into zone_latched.
- ALARM:
  - siren = 1, registered; it asserts the cycle after entering ALARM.
  - code_ok -> DISARMED.
  - timeout -> ARMED with siren off, so the system re-arms. Open zones are latched again on the next cycle.
- Priority within one cycle: clear > code_ok > instant trip > timeout > entry trip > arm. code_ok and a sensor trip in the same cycle -> DISARMED, and that trip is not latched.
- zone_latched: cleared only on the DISARMED -> EXIT_DELAY transition (new arm) or on clear. It is retained through DISARMED for readout.
- Input filtering: arm while not DISARMED is ignored with no fault. code_ok in DISARMED is ignored. tick and arm in the same cycle from DISARMED: arm is accepted and count loads EXIT_TICKS; that tick is not consumed.
- Outputs: all outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package alarm_pkg:
  - state code constants DISARMED..ALARM;
  - a state width constant of 3;
  - a helper function for CW.
- Sub-module tick_timer:
  - loadable down-counter with inputs load, load_value, tick and clear;
  - outputs count and done, where done = tick && count==1;
  - instantiated once and reloaded on each timed-state entry.

Test Plan:
- Reset and idle: assert clear during ALARM -> next clk gives state=0, siren=0, zone_latched=0, count=0.
- Arm fault: sensor=4'b0100, arm pulse -> arm_fault high for 1 cycle, state stays 0. Repeat with sensor=0 -> state=1, count=10.
- Exit then entry: arm, 10 ticks -> state=2. Set sensor=4'b0001 -> state=3, count=8. After 8 ticks -> state=4, siren=1, zone_latched=4'b0001.
- Instant zone during entry: in ENTRY_DELAY with count=5, sensor=4'b0011 -> state=4 next clk, zone_latched=4'b0011.
- Disarm races: in ARMED, code_ok and sensor=4'b0010 in the same cycle -> state=0, zone_latched unchanged. code_ok at count=1 coinciding with a tick in ENTRY_DELAY -> state=0, no siren.
- Alarm timeout: in ALARM, 60 ticks -> state=2, siren=0, zone_latched retained. A new arm from DISARMED clears zone_latched.
